// File: rtl/fp_rf_pkg.sv
// fp_rf_pkg: shared CSR encodings, fcsr field widths and fflags bit positions for the FP register file.
package fp_rf_pkg;
  typedef enum logic [1:0] {CSR_WRITE, CSR_SET, CSR_CLEAR, CSR_READ} csr_op_t;
  typedef enum logic [1:0] {SEL_FFLAGS, SEL_FRM, SEL_FCSR, SEL_RSVD} csr_sel_t;
  localparam int FFLAGS_W = 5;
  localparam int FRM_W = 3;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
endpackage

// File: rtl/fp_regfile_scoreboard_if.sv
// fp_regfile_scoreboard_if: bundle of read ports, issue, FPU/load writeback, CSR access and status outputs.
// master drives addresses, writebacks and CSR requests; slave (the register file) returns read data and status.
interface fp_regfile_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3
);
  localparam int AW = $clog2(NUM_REGS);
  logic [NUM_RPORTS*AW-1:0]         rd_addr;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RPORTS-1:0]            rd_busy;
  logic                             issue_en;
  logic [AW-1:0]                    issue_rd;
  logic                             fpu_wen;
  logic [AW-1:0]                    fpu_waddr;
  logic [DATA_WIDTH-1:0]            fpu_wdata;
  logic [4:0]                       fpu_flags;
  logic                             ld_wen;
  logic [AW-1:0]                    ld_waddr;
  logic [DATA_WIDTH-1:0]            ld_wdata;
  logic                             csr_en;
  logic [1:0]                       csr_op;
  logic [1:0]                       csr_sel;
  logic [7:0]                       csr_wdata;
  logic [7:0]                       csr_rdata;
  logic [2:0]                       frm_out;
  logic [4:0]                       fflags_out;
  logic                             wr_collision;
  logic                             sb_idle;
  modport master (
    output rd_addr, issue_en, issue_rd, fpu_wen, fpu_waddr, fpu_wdata, fpu_flags,
           ld_wen, ld_waddr, ld_wdata, csr_en, csr_op, csr_sel, csr_wdata,
    input  rd_data, rd_busy, csr_rdata, frm_out, fflags_out, wr_collision, sb_idle
  );
  modport slave (
    input  rd_addr, issue_en, issue_rd, fpu_wen, fpu_waddr, fpu_wdata, fpu_flags,
           ld_wen, ld_waddr, ld_wdata, csr_en, csr_op, csr_sel, csr_wdata,
    output rd_data, rd_busy, csr_rdata, frm_out, fflags_out, wr_collision, sb_idle
  );
endinterface

// File: rtl/fp_scoreboard.sv
// fp_scoreboard: per-register busy bits for in-flight FPU results.
// Ports: clk, n_rst (async active-low), issue_en/issue_rd set a bit, fpu/ld write enables+addresses clear it,
// busy is the registered vector, sb_idle is high when no bit is set.
module fp_scoreboard #(
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        issue_en,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
  input  logic                        fpu_wen,
  input  logic [$clog2(NUM_REGS)-1:0] fpu_waddr,
  input  logic                        ld_wen,
  input  logic [$clog2(NUM_REGS)-1:0] ld_waddr,
  output logic [NUM_REGS-1:0]         busy,
  output logic                        sb_idle
);
  logic [NUM_REGS-1:0] set_v, clr_v;
  always_comb begin
    set_v = '0;
    clr_v = '0;
    set_v[issue_rd] = issue_en;
    clr_v[fpu_waddr] = fpu_wen;
    if (ld_wen) clr_v[ld_waddr] = 1'b1;
  end
  // set is applied after clear so a new producer issued in the writeback cycle stays in flight
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) busy <= '0;
    else busy <= (busy & ~clr_v) | set_v;
  assign sb_idle = ~|busy;
endmodule

// File: rtl/fp_regfile_scoreboard.sv
// fp_regfile_scoreboard: FP register file with bypassed read ports, FPU/load write ports, busy scoreboard and fcsr.
// Ports: clk, n_rst (async active-low), bus (slave side of fp_regfile_scoreboard_if carrying reads,
// issue, writebacks, CSR access, frm/fflags, wr_collision and sb_idle).
module fp_regfile_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3
) (
  input logic                    clk,
  input logic                    n_rst,
  fp_regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  collide, ld_keep;
  logic [FFLAGS_W-1:0]   fflags, fflags_n;
  logic [FRM_W-1:0]      frm, frm_n;
  logic [7:0]            cur, upd;
  csr_op_t               op;
  csr_sel_t              sel;
  // FPU port wins a same-address collision; the load is dropped
  assign collide = bus.fpu_wen && bus.ld_wen && bus.fpu_waddr == bus.ld_waddr;
  assign ld_keep = bus.ld_wen && !collide;
  assign bus.wr_collision = collide;
  fp_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk      (clk),
    .n_rst    (n_rst),
    .issue_en (bus.issue_en),
    .issue_rd (bus.issue_rd),
    .fpu_wen  (bus.fpu_wen),
    .fpu_waddr(bus.fpu_waddr),
    .ld_wen   (bus.ld_wen),
    .ld_waddr (bus.ld_waddr),
    .busy     (busy),
    .sb_idle  (bus.sb_idle)
  );
  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit_f, hit_l;
    assign a = bus.rd_addr[p*AW +: AW];
    assign hit_f = bus.fpu_wen && bus.fpu_waddr == a;
    assign hit_l = bus.ld_wen && bus.ld_waddr == a;
    assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = hit_f ? bus.fpu_wdata : hit_l ? bus.ld_wdata : regs[a];
    assign bus.rd_busy[p] = busy[a] && !(hit_f || hit_l);
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (bus.fpu_wen) regs[bus.fpu_waddr] <= bus.fpu_wdata;
      if (ld_keep) regs[bus.ld_waddr] <= bus.ld_wdata;
    end
  assign op = csr_op_t'(bus.csr_op);
  assign sel = csr_sel_t'(bus.csr_sel);
  // CSR update is applied first, then this cycle's FPU flags are accrued on top
  always_comb begin
    cur = sel == SEL_FFLAGS ? {3'b0, fflags} : sel == SEL_FRM ? {5'b0, frm} : sel == SEL_FCSR ? {frm, fflags} : 8'h0;
    upd = op == CSR_WRITE ? bus.csr_wdata : op == CSR_SET ? cur | bus.csr_wdata : cur & ~bus.csr_wdata;
    frm_n = frm;
    fflags_n = fflags;
    if (bus.csr_en && op != CSR_READ) begin
      if (sel == SEL_FFLAGS || sel == SEL_FCSR) fflags_n = upd[4:0];
      if (sel == SEL_FRM) frm_n = upd[2:0];
      if (sel == SEL_FCSR) frm_n = upd[7:5];
    end
    fflags_n = fflags_n | (bus.fpu_wen ? bus.fpu_flags : 5'b0);
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      frm <= '0;
      fflags <= '0;
    end else begin
      frm <= frm_n;
      fflags <= fflags_n;
    end
  assign bus.csr_rdata = cur;
  assign bus.frm_out = frm;
  assign bus.fflags_out = fflags;
endmodule

// File: tb/tb_fp_regfile_scoreboard.sv
// tb_fp_regfile_scoreboard: directed and random stimulus against a behavioural model of the FP register file.
module tb_fp_regfile_scoreboard;
  localparam int NR = 32, DW = 32, NP = 3, AW = 5;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;
  fp_regfile_scoreboard_if #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RPORTS(NP)) bus ();
  fp_regfile_scoreboard #(.NUM_REGS(NR), .DATA_WIDTH(DW), .NUM_RPORTS(NP)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  logic [4:0]    m_ff;
  logic [2:0]    m_frm;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.rd_addr = '0; bus.issue_en = 0; bus.issue_rd = '0;
    bus.fpu_wen = 0; bus.fpu_waddr = '0; bus.fpu_wdata = '0; bus.fpu_flags = '0;
    bus.ld_wen = 0; bus.ld_waddr = '0; bus.ld_wdata = '0;
    bus.csr_en = 0; bus.csr_op = 2'd3; bus.csr_sel = 2'd0; bus.csr_wdata = '0;
  endtask
  task automatic set_rd(input int p, input int a);
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask
  function automatic logic [DW-1:0] rd_slice(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction
  function automatic bit wr_hits(input int a);
    return (bus.fpu_wen && int'(bus.fpu_waddr) == a) || (bus.ld_wen && int'(bus.ld_waddr) == a);
  endfunction
  function automatic logic [7:0] csr_old();
    case (bus.csr_sel)
      2'd0: return {3'b0, m_ff};
      2'd1: return {5'b0, m_frm};
      2'd2: return {m_frm, m_ff};
      default: return 8'h0;
    endcase
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    m_ff = '0; m_frm = '0;
  endtask
  task automatic model_edge();
    logic [7:0] old, nv;
    bit coll;
    coll = bus.fpu_wen && bus.ld_wen && bus.fpu_waddr == bus.ld_waddr;
    old = csr_old();
    nv = old;
    if (bus.csr_en && bus.csr_op != 2'd3 && bus.csr_sel != 2'd3) begin
      if (bus.csr_op == 2'd0) nv = bus.csr_wdata;
      else if (bus.csr_op == 2'd1) nv = old | bus.csr_wdata;
      else nv = old & ~bus.csr_wdata;
      if (bus.csr_sel == 2'd0) m_ff = nv[4:0];
      else if (bus.csr_sel == 2'd1) m_frm = nv[2:0];
      else {m_frm, m_ff} = nv;
    end
    if (bus.fpu_wen) m_ff = m_ff | bus.fpu_flags;
    if (bus.fpu_wen) begin m_regs[bus.fpu_waddr] = bus.fpu_wdata; m_busy[bus.fpu_waddr] = 0; end
    if (bus.ld_wen) begin
      if (!coll) m_regs[bus.ld_waddr] = bus.ld_wdata;
      m_busy[bus.ld_waddr] = 0;
    end
    if (bus.issue_en) m_busy[bus.issue_rd] = 1;
  endtask
  task automatic check_all();
    int a;
    logic [DW-1:0] e;
    bit idle_e;
    for (int p = 0; p < NP; p++) begin
      a = int'(bus.rd_addr[p*AW +: AW]);
      e = (bus.fpu_wen && int'(bus.fpu_waddr) == a) ? bus.fpu_wdata :
          (bus.ld_wen && int'(bus.ld_waddr) == a) ? bus.ld_wdata : m_regs[a];
      chk($sformatf("rd_data[%0d]", p), rd_slice(p), e);
      chk($sformatf("rd_busy[%0d]", p), bus.rd_busy[p], m_busy[a] && !wr_hits(a));
    end
    idle_e = 1;
    for (int i = 0; i < NR; i++) if (m_busy[i]) idle_e = 0;
    chk("wr_collision", bus.wr_collision, bus.fpu_wen && bus.ld_wen && bus.fpu_waddr == bus.ld_waddr);
    chk("sb_idle", bus.sb_idle, idle_e);
    chk("csr_rdata", bus.csr_rdata, csr_old());
    chk("frm_out", bus.frm_out, m_frm);
    chk("fflags_out", bus.fflags_out, m_ff);
  endtask
  task automatic at_neg();
    @(negedge clk);
    check_all();
  endtask
  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  initial begin
    idle();
    model_reset();
    #12 n_rst = 1;
    @(posedge clk); #1;
    // reset state
    set_rd(0, 3); set_rd(1, 2); set_rd(2, 31);
    at_neg();
    chk("rst_rd0", rd_slice(0), 0);
    chk("rst_busy", bus.rd_busy, 0);
    chk("rst_csr", bus.csr_rdata, 0);
    chk("rst_idle", bus.sb_idle, 1);
    edge_step();
    // load write, bypass in the write cycle, then stored value
    idle(); bus.ld_wen = 1; bus.ld_waddr = 5; bus.ld_wdata = 32'h3F800000; set_rd(0, 5);
    at_neg();
    chk("ld_bypass", rd_slice(0), 32'h3F800000);
    edge_step();
    idle(); set_rd(0, 5);
    at_neg();
    chk("ld_stored", rd_slice(0), 32'h3F800000);
    edge_step();
    // both ports to reg7
    idle(); bus.fpu_wen = 1; bus.fpu_waddr = 7; bus.fpu_wdata = 32'h40000000;
    bus.ld_wen = 1; bus.ld_waddr = 7; bus.ld_wdata = 32'h11111111; set_rd(1, 7);
    at_neg();
    chk("coll_flag", bus.wr_collision, 1);
    chk("coll_bypass", rd_slice(1), 32'h40000000);
    edge_step();
    idle(); set_rd(1, 7);
    at_neg();
    chk("coll_stored", rd_slice(1), 32'h40000000);
    chk("coll_clear", bus.wr_collision, 0);
    edge_step();
    // scoreboard
    idle(); bus.issue_en = 1; bus.issue_rd = 3; set_rd(2, 3);
    at_neg();
    chk("issue_same_cyc", bus.rd_busy[2], 0);
    edge_step();
    idle(); set_rd(2, 3);
    at_neg();
    chk("busy_set", bus.rd_busy[2], 1);
    chk("busy_notidle", bus.sb_idle, 0);
    edge_step();
    idle(); bus.fpu_wen = 1; bus.fpu_waddr = 3; bus.fpu_wdata = 32'h1; bus.fpu_flags = 5'h01; set_rd(2, 3);
    at_neg();
    chk("busy_wb_byp", bus.rd_busy[2], 0);
    edge_step();
    idle(); bus.issue_en = 1; bus.issue_rd = 3;
    bus.fpu_wen = 1; bus.fpu_waddr = 3; bus.fpu_wdata = 32'h2; bus.fpu_flags = 5'h10;
    at_neg();
    edge_step();
    idle(); set_rd(2, 3);
    at_neg();
    chk("busy_setwins", bus.rd_busy[2], 1);
    chk("flags_accrue", bus.fflags_out, 5'h11);
    edge_step();
    // CSR on fflags
    idle(); bus.csr_en = 1; bus.csr_op = 2'd3; bus.csr_sel = 2'd0;
    at_neg();
    chk("csr_read_ff", bus.csr_rdata, 8'h11);
    edge_step();
    idle(); bus.csr_en = 1; bus.csr_op = 2'd2; bus.csr_sel = 2'd0; bus.csr_wdata = 8'h01;
    bus.fpu_wen = 1; bus.fpu_waddr = 3; bus.fpu_wdata = 32'h3; bus.fpu_flags = 5'h04;
    at_neg();
    edge_step();
    idle();
    at_neg();
    chk("clear_plus_flags", bus.fflags_out, 5'h14);
    edge_step();
    // fcsr write, read-old
    idle(); bus.csr_en = 1; bus.csr_op = 2'd0; bus.csr_sel = 2'd2; bus.csr_wdata = 8'hE5;
    at_neg();
    chk("fcsr_read_old", bus.csr_rdata, 8'h14);
    edge_step();
    idle(); set_rd(0, 5); set_rd(1, 7); set_rd(2, 3);
    at_neg();
    chk("frm_written", bus.frm_out, 3'd7);
    chk("ff_written", bus.fflags_out, 5'h05);
    // async reset mid-cycle, with a busy register pending
    bus.issue_en = 1; bus.issue_rd = 9;
    edge_step();
    idle(); set_rd(0, 5); set_rd(1, 7); set_rd(2, 3);
    #2 n_rst = 0;
    #1;
    model_reset();
    chk("arst_rd0", rd_slice(0), 0);
    chk("arst_rd1", rd_slice(1), 0);
    chk("arst_idle", bus.sb_idle, 1);
    chk("arst_frm", bus.frm_out, 0);
    chk("arst_ff", bus.fflags_out, 0);
    @(negedge clk);
    n_rst = 1;
    @(posedge clk); #1;
    // late writeback after reset still writes
    idle(); bus.fpu_wen = 1; bus.fpu_waddr = 9; bus.fpu_wdata = 32'hCAFE0001;
    at_neg();
    edge_step();
    idle(); set_rd(0, 9);
    at_neg();
    chk("late_wb", rd_slice(0), 32'hCAFE0001);
    edge_step();
    // random traffic against the model
    for (int c = 0; c < 500; c++) begin
      for (int p = 0; p < NP; p++) set_rd(p, $urandom_range(0, NR - 1));
      bus.issue_en = ($urandom_range(0, 2) == 0);
      bus.issue_rd = AW'($urandom_range(0, NR - 1));
      bus.fpu_wen = ($urandom_range(0, 2) == 0);
      bus.fpu_waddr = AW'($urandom_range(0, 7));
      bus.fpu_wdata = DW'($urandom);
      bus.fpu_flags = 5'($urandom);
      bus.ld_wen = ($urandom_range(0, 2) == 0);
      bus.ld_waddr = AW'($urandom_range(0, 7));
      bus.ld_wdata = DW'($urandom);
      bus.csr_en = ($urandom_range(0, 3) == 0);
      bus.csr_op = 2'($urandom);
      bus.csr_sel = 2'($urandom);
      bus.csr_wdata = 8'($urandom);
      at_neg();
      edge_step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
